piggy_coin_formatter: RTL and testbench



---
 rtl/piggy_coin_formatter.sv | 206 ++++++++++++++++++++
 tb/tb_piggy_coin_formatter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piggy_coin_formatter.sv
// Piggy-bank coin accumulator and decimal ASCII report formatter.
// Sums coin pulses into a saturating total and streams "<digits> CR LF" to a UART TX.
module piggy_coin_formatter #(
  parameter int unsigned TOTAL_W       = 14,
  parameter int unsigned MAX_TOTAL     = 9999,
  parameter bit          CLEAR_ON_SEND = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin10,
  input  logic               coin5,
  input  logic               coin2,
  input  logic               coin1,
  input  logic               send,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic [TOTAL_W-1:0] total,
  output logic               busy,
  output logic               send_dropped
);

  localparam int unsigned SUM_W  = TOTAL_W + 1;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned DD_W   = BCD_W + TOTAL_W;
  localparam int unsigned CNT_W  = $clog2(TOTAL_W + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONVERT = 3'd1;
  localparam logic [2:0] ST_EMIT    = 3'd2;
  localparam logic [2:0] ST_CR      = 3'd3;
  localparam logic [2:0] ST_LF      = 3'd4;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  logic [2:0]         state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [TOTAL_W-1:0] bin_sr, bin_sr_next;
  logic [BCD_W-1:0]   bcd, bcd_next;
  logic [1:0]         dig_idx, dig_idx_next;
  logic               tx_valid_next;
  logic [7:0]         tx_data_next;
  logic               busy_next;
  logic               send_dropped_next;
  logic [TOTAL_W-1:0] total_next;
  logic               send_accept;

  logic [4:0]         coin_inc;
  logic [SUM_W-1:0]   acc_base;
  logic [SUM_W-1:0]   acc_sum;
  logic [DD_W-1:0]    dd_out;
  logic [BCD_W-1:0]   dd_bcd;
  logic [1:0]         lead_idx;
  logic [3:0]         cur_digit;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
  function automatic logic [DD_W-1:0] dd_step(input logic [BCD_W-1:0] b_in,
                                              input logic [TOTAL_W-1:0] s_in);
    logic [BCD_W-1:0] b;
    b = b_in;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        b[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return {b[BCD_W-2:0], s_in, 1'b0};
  endfunction

  assign dd_out = dd_step(bcd, bin_sr);
  assign dd_bcd = dd_out[DD_W-1 -: BCD_W];

  // Most significant non-zero digit of the finished conversion; digit 0 if all zero.
  always_comb begin
    lead_idx = 2'd0;
    if (dd_bcd[15:12] != 4'd0) begin
      lead_idx = 2'd3;
    end else if (dd_bcd[11:8] != 4'd0) begin
      lead_idx = 2'd2;
    end else if (dd_bcd[7:4] != 4'd0) begin
      lead_idx = 2'd1;
    end
  end

  always_comb begin
    cur_digit = bcd[3:0];
    case (dig_idx)
      2'd3:    cur_digit = bcd[15:12];
      2'd2:    cur_digit = bcd[11:8];
      2'd1:    cur_digit = bcd[7:4];
      default: cur_digit = bcd[3:0];
    endcase
  end

  // Saturating accumulator; the sum is one bit wider so it cannot wrap before the clamp.
  always_comb begin
    coin_inc = (coin10 ? 5'd10 : 5'd0) + (coin5 ? 5'd5 : 5'd0)
             + (coin2 ? 5'd2 : 5'd0) + (coin1 ? 5'd1 : 5'd0);
    acc_base = (CLEAR_ON_SEND && send_accept) ? '0 : {1'b0, total};
    acc_sum  = acc_base + SUM_W'(coin_inc);
    total_next = (acc_sum > SUM_W'(MAX_TOTAL)) ? TOTAL_W'(MAX_TOTAL)
                                               : acc_sum[TOTAL_W-1:0];
  end

  // Next-state and registered-output logic for the report sequencer.
  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    bin_sr_next       = bin_sr;
    bcd_next          = bcd;
    dig_idx_next      = dig_idx;
    tx_valid_next     = tx_valid;
    tx_data_next      = tx_data;
    send_accept       = 1'b0;
    send_dropped_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (send) begin
          send_accept = 1'b1;
          state_next  = ST_CONVERT;
          cnt_next    = '0;
          bin_sr_next = total;
          bcd_next    = '0;
        end
      end
      ST_CONVERT: begin
        {bcd_next, bin_sr_next} = dd_out;
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(TOTAL_W - 1)) begin
          state_next   = ST_EMIT;
          dig_idx_next = lead_idx;
        end
      end
      ST_EMIT: begin
        if (!tx_valid) begin
          tx_valid_next = 1'b1;
          tx_data_next  = ASCII_ZERO + 8'(cur_digit);
        end else if (tx_ready) begin
          tx_valid_next = 1'b0;
          if (dig_idx == 2'd0) begin
            state_next = ST_CR;
          end else begin
            dig_idx_next = dig_idx - 2'd1;
          end
        end
      end
      ST_CR: begin
        if (!tx_valid) begin
          tx_valid_next = 1'b1;
          tx_data_next  = ASCII_CR;
        end else if (tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = ST_LF;
        end
      end
      ST_LF: begin
        if (!tx_valid) begin
          tx_valid_next = 1'b1;
          tx_data_next  = ASCII_LF;
        end else if (tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = ST_IDLE;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        tx_valid_next = 1'b0;
      end
    endcase

    if (send && (state != ST_IDLE)) begin
      send_dropped_next = 1'b1;
    end
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bin_sr       <= '0;
      bcd          <= '0;
      dig_idx      <= 2'd0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      busy         <= 1'b0;
      send_dropped <= 1'b0;
      total        <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      bin_sr       <= bin_sr_next;
      bcd          <= bcd_next;
      dig_idx      <= dig_idx_next;
      tx_valid     <= tx_valid_next;
      tx_data      <= tx_data_next;
      busy         <= busy_next;
      send_dropped <= send_dropped_next;
      total        <= total_next;
    end
  end

endmodule

// File: tb/tb_piggy_coin_formatter.sv
// Bench for piggy_coin_formatter: scenario tasks checked against a decimal-string reference model.
module tb_piggy_coin_formatter;

  logic        clk;
  logic        rst;
  logic        coin10, coin5, coin2, coin1;
  logic        send;
  logic        tx_ready;
  logic        tx_valid, c_tx_valid;
  logic [7:0]  tx_data, c_tx_data;
  logic [13:0] total, c_total;
  logic        busy, c_busy;
  logic        send_dropped, c_send_dropped;

  int errors = 0;
  int checks = 0;
  int model_total = 0;
  int drop_cnt = 0;
  logic [7:0] cap_q[$];
  logic [7:0] cap_c[$];

  piggy_coin_formatter dut (
    .clk(clk), .rst(rst), .coin10(coin10), .coin5(coin5), .coin2(coin2), .coin1(coin1),
    .send(send), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .total(total), .busy(busy), .send_dropped(send_dropped)
  );

  piggy_coin_formatter #(.CLEAR_ON_SEND(1'b1)) dut_c (
    .clk(clk), .rst(rst), .coin10(coin10), .coin5(coin5), .coin2(coin2), .coin1(coin1),
    .send(send), .tx_ready(tx_ready), .tx_valid(c_tx_valid), .tx_data(c_tx_data),
    .total(c_total), .busy(c_busy), .send_dropped(c_send_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte and drop-pulse capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) cap_q.push_back(tx_data);
    if (c_tx_valid && tx_ready) cap_c.push_back(c_tx_data);
    if (send_dropped) drop_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected report: decimal text of the snapshot followed by CR LF.
  function automatic string report_of(int v);
    return $sformatf("%0d%c%c", v, 8'h0D, 8'h0A);
  endfunction

  function automatic int sat_add(int a, int inc);
    return (a + inc > 9999) ? 9999 : a + inc;
  endfunction

  task automatic drive_cycle(input logic [3:0] coins, input logic snd, input logic rdy);
    {coin10, coin5, coin2, coin1} = coins;
    send = snd;
    tx_ready = rdy;
    model_total = sat_add(model_total, 10 * int'(coins[3]) + 5 * int'(coins[2])
                                       + 2 * int'(coins[1]) + int'(coins[0]));
    @(posedge clk);
    #1;
    {coin10, coin5, coin2, coin1} = 4'b0000;
    send = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {coin10, coin5, coin2, coin1} = 4'b0000;
    send = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_total = 0;
  endtask

  function automatic logic [3:0] rand_coins();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
  endfunction

  task automatic wait_report(input bit rand_rdy, input bit rand_coin, output bit done);
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      drive_cycle(rand_coin ? rand_coins() : 4'b0000, 1'b0,
                  rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {coin10, coin5, coin2, coin1} = 4'b0000;
    send = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (total !== 14'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", total); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (send_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b want 0", send_dropped); end
    checks++; if (c_total !== 14'd0) begin errors++; $display("FAIL reset_c_total: got %0d want 0", c_total); end
    rst = 1'b0;
    model_total = 0;
  endtask

  task automatic test_basic();
    int base, n, snap;
    bit done;
    string s;
    do_reset();
    drive_cycle(4'b1000, 1'b0, 1'b1);
    drive_cycle(4'b0100, 1'b0, 1'b1);
    drive_cycle(4'b0010, 1'b0, 1'b1);
    drive_cycle(4'b0001, 1'b0, 1'b1);
    checks++; if (total !== 14'(model_total)) begin errors++; $display("FAIL basic_total: got %0d want %0d", total, model_total); end
    snap = model_total;
    base = cap_q.size();
    drive_cycle(4'b0000, 1'b1, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    n = 1;
    while (!tx_valid && n < 100) begin
      drive_cycle(4'b0000, 1'b0, 1'b1);
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL basic_latency: got %0d cycles want 16", n); end
    wait_report(1'b0, 1'b0, done);
    checks++; if (!done) begin errors++; $display("FAIL basic_timeout: busy still %b want 0", busy); end
    s = report_of(snap);
    checks++;
    if (cap_q.size() - base !== s.len()) begin
      errors++; $display("FAIL basic_len: got %0d bytes want %0d", cap_q.size() - base, s.len());
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        checks++;
        if (cap_q[base + i] !== s[i]) begin errors++; $display("FAIL basic_byte%0d: got %02h want %02h", i, cap_q[base + i], s[i]); end
      end
    end
  endtask

  task automatic test_zero_and_clear();
    int base, base_c;
    bit done;
    string s;
    do_reset();
    base = cap_q.size();
    drive_cycle(4'b0000, 1'b1, 1'b1);
    wait_report(1'b0, 1'b0, done);
    checks++; if (!done) begin errors++; $display("FAIL zero_timeout: busy still %b want 0", busy); end
    s = report_of(0);
    checks++;
    if (cap_q.size() - base !== s.len()) begin
      errors++; $display("FAIL zero_len: got %0d bytes want %0d", cap_q.size() - base, s.len());
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        checks++;
        if (cap_q[base + i] !== s[i]) begin errors++; $display("FAIL zero_byte%0d: got %02h want %02h", i, cap_q[base + i], s[i]); end
      end
    end
    // Build 907 on both instances, then send; the clearing instance must read 0.
    do_reset();
    for (int i = 0; i < 90; i++) drive_cycle(4'b1000, 1'b0, 1'b1);
    drive_cycle(4'b0100, 1'b0, 1'b1);
    drive_cycle(4'b0010, 1'b0, 1'b1);
    checks++; if (c_total !== 14'd907) begin errors++; $display("FAIL clear_pre_total: got %0d want 907", c_total); end
    base_c = cap_c.size();
    drive_cycle(4'b0000, 1'b1, 1'b1);
    checks++; if (c_total !== 14'd0) begin errors++; $display("FAIL clear_total_zero: got %0d want 0", c_total); end
    checks++; if (total !== 14'(model_total)) begin errors++; $display("FAIL clear_keep_total: got %0d want %0d", total, model_total); end
    wait_report(1'b0, 1'b0, done);
    checks++; if (!done) begin errors++; $display("FAIL clear_timeout: busy still %b want 0", busy); end
    s = report_of(907);
    checks++;
    if (cap_c.size() - base_c !== s.len()) begin
      errors++; $display("FAIL clear_len: got %0d bytes want %0d", cap_c.size() - base_c, s.len());
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        checks++;
        if (cap_c[base_c + i] !== s[i]) begin errors++; $display("FAIL clear_byte%0d: got %02h want %02h", i, cap_c[base_c + i], s[i]); end
      end
    end
    drive_cycle(4'b0100, 1'b1, 1'b1);
    checks++; if (c_total !== 14'd5) begin errors++; $display("FAIL clear_same_cycle_coin: got %0d want 5", c_total); end
    wait_report(1'b0, 1'b0, done);
  endtask

  task automatic test_saturate();
    int base;
    bit done;
    string s;
    do_reset();
    for (int i = 0; i < 555; i++) drive_cycle(4'b1111, 1'b0, 1'b0);
    checks++; if (total !== 14'(model_total)) begin errors++; $display("FAIL sat_near: got %0d want %0d", total, model_total); end
    for (int i = 0; i < 45; i++) drive_cycle(4'b1111, 1'b0, 1'b0);
    checks++; if (total !== 14'(model_total)) begin errors++; $display("FAIL sat_total: got %0d want %0d", total, model_total); end
    base = cap_q.size();
    drive_cycle(4'b0000, 1'b1, 1'b1);
    wait_report(1'b0, 1'b0, done);
    checks++; if (!done) begin errors++; $display("FAIL sat_timeout: busy still %b want 0", busy); end
    s = report_of(9999);
    checks++;
    if (cap_q.size() - base !== s.len()) begin
      errors++; $display("FAIL sat_len: got %0d bytes want %0d", cap_q.size() - base, s.len());
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        checks++;
        if (cap_q[base + i] !== s[i]) begin errors++; $display("FAIL sat_byte%0d: got %02h want %02h", i, cap_q[base + i], s[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int base, drops0, n, bad;
    bit done;
    string s;
    do_reset();
    for (int i = 0; i < 12; i++) drive_cycle(4'b1000, 1'b0, 1'b0);
    drive_cycle(4'b0100, 1'b0, 1'b0);
    drive_cycle(4'b0010, 1'b0, 1'b0);
    s = report_of(model_total);
    base = cap_q.size();
    drops0 = drop_cnt;
    drive_cycle(4'b0000, 1'b1, 1'b0);
    n = 0;
    while (!tx_valid && n < 100) begin
      drive_cycle(4'b0000, 1'b0, 1'b0);
      n++;
    end
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", tx_valid); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      drive_cycle(4'b0000, (i == 10), 1'b0);
      if (tx_valid !== 1'b1 || tx_data !== 8'h31) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles want 0 (valid %b data %02h)", bad, tx_valid, tx_data); end
    wait_report(1'b0, 1'b0, done);
    checks++; if (!done) begin errors++; $display("FAIL bp_timeout: busy still %b want 0", busy); end
    checks++; if (drop_cnt - drops0 !== 1) begin errors++; $display("FAIL bp_dropped: got %0d pulses want 1", drop_cnt - drops0); end
    checks++;
    if (cap_q.size() - base !== s.len()) begin
      errors++; $display("FAIL bp_len: got %0d bytes want %0d", cap_q.size() - base, s.len());
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        checks++;
        if (cap_q[base + i] !== s[i]) begin errors++; $display("FAIL bp_byte%0d: got %02h want %02h", i, cap_q[base + i], s[i]); end
      end
    end
  endtask

  task automatic test_same_cycle_coin();
    int base, snap;
    bit done;
    string s;
    do_reset();
    drive_cycle(4'b1000, 1'b0, 1'b1);
    drive_cycle(4'b1000, 1'b0, 1'b1);
    snap = model_total;
    base = cap_q.size();
    drive_cycle(4'b0100, 1'b1, 1'b1);
    checks++; if (total !== 14'(model_total)) begin errors++; $display("FAIL same_total: got %0d want %0d", total, model_total); end
    wait_report(1'b0, 1'b0, done);
    s = report_of(snap);
    checks++;
    if (cap_q.size() - base !== s.len()) begin
      errors++; $display("FAIL same_len: got %0d bytes want %0d", cap_q.size() - base, s.len());
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        checks++;
        if (cap_q[base + i] !== s[i]) begin errors++; $display("FAIL same_byte%0d: got %02h want %02h", i, cap_q[base + i], s[i]); end
      end
    end
  endtask

  task automatic test_reset_abort();
    int base, n;
    bit done;
    string s;
    do_reset();
    drive_cycle(4'b1000, 1'b0, 1'b1);
    drive_cycle(4'b0100, 1'b0, 1'b1);
    drive_cycle(4'b0010, 1'b0, 1'b1);
    drive_cycle(4'b0001, 1'b0, 1'b1);
    base = cap_q.size();
    drive_cycle(4'b0000, 1'b1, 1'b1);
    n = 0;
    while (cap_q.size() < base + 2 && n < 100) begin
      drive_cycle(4'b0000, 1'b0, 1'b1);
      n++;
    end
    checks++; if (cap_q.size() - base !== 2) begin errors++; $display("FAIL abort_two_bytes: got %0d want 2", cap_q.size() - base); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid: got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (total !== 14'd0) begin errors++; $display("FAIL abort_total: got %0d want 0", total); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_total = 0;
    base = cap_q.size();
    for (int i = 0; i < 40; i++) drive_cycle(4'b0000, 1'b0, 1'b1);
    checks++; if (cap_q.size() !== base) begin errors++; $display("FAIL abort_no_bytes: got %0d bytes want 0", cap_q.size() - base); end
    drive_cycle(4'b0000, 1'b1, 1'b1);
    wait_report(1'b0, 1'b0, done);
    s = report_of(0);
    checks++;
    if (cap_q.size() - base !== s.len()) begin
      errors++; $display("FAIL abort_len: got %0d bytes want %0d", cap_q.size() - base, s.len());
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        checks++;
        if (cap_q[base + i] !== s[i]) begin errors++; $display("FAIL abort_byte%0d: got %02h want %02h", i, cap_q[base + i], s[i]); end
      end
    end
  endtask

  task automatic test_random();
    int base, snap, k;
    bit done;
    string s;
    do_reset();
    for (int r = 0; r < 15; r++) begin
      k = $urandom_range(0, 80);
      for (int i = 0; i < k; i++) drive_cycle(4'($urandom), 1'b0, 1'b0);
      checks++; if (total !== 14'(model_total)) begin errors++; $display("FAIL rand%0d_total_pre: got %0d want %0d", r, total, model_total); end
      snap = model_total;
      base = cap_q.size();
      drive_cycle(rand_coins(), 1'b1, 1'($urandom_range(0, 1)));
      wait_report(1'b1, 1'b1, done);
      checks++; if (!done) begin errors++; $display("FAIL rand%0d_timeout: busy still %b want 0", r, busy); end
      checks++; if (total !== 14'(model_total)) begin errors++; $display("FAIL rand%0d_total: got %0d want %0d", r, total, model_total); end
      s = report_of(snap);
      checks++;
      if (cap_q.size() - base !== s.len()) begin
        errors++; $display("FAIL rand%0d_len: got %0d bytes want %0d", r, cap_q.size() - base, s.len());
      end else begin
        for (int i = 0; i < s.len(); i++) begin
          checks++;
          if (cap_q[base + i] !== s[i]) begin errors++; $display("FAIL rand%0d_byte%0d: got %02h want %02h", r, i, cap_q[base + i], s[i]); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {coin10, coin5, coin2, coin1} = 4'b0000;
    send = 1'b0;
    tx_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_and_clear();
    test_saturate();
    test_backpressure();
    test_same_cycle_coin();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
